aes_inv_mixcolumns: RTL
=======================

// Module: aes_inv_mixcolumns
// PURPOSE
//  Iterative AES InvMixColumns engine (FIPS-197 5.3.3), decrypt-side counterpart of aes_mixcolumns.
//  Accepts a 128-bit state as four 32-bit columns and returns the inverse-mixed state with a done pulse.
//  Processes COLS_PER_CYCLE columns per clock. It sits in the decryption round datapath after AddRoundKey.
//  Port order and handshake style match aes_mixcolumns, so the two blocks can be swapped or chained in benches.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns transformed per clock; legal values are 1, 2 and 4. Latency L = 4/COLS_PER_CYCLE.
// PORTS
//  clk            in   1   single clock; all state changes on rising edge
//  reset          in   1   asynchronous, active-high; clears all state immediately
//  start_in       in   1   request; level-sampled in IDLE only
//  state0         in   32  column 0; byte r (row r) = state0[8r+7:8r], row 0 in LSB
//  state1         in   32  column 1, same packing
//  state2         in   32  column 2, same packing
//  state3         in   32  column 3, same packing
//  state_out0     out  32  InvMixColumns(column 0), same packing
//  state_out1     out  32  InvMixColumns(column 1)
//  state_out2     out  32  InvMixColumns(column 2)
//  state_out3     out  32  InvMixColumns(column 3)
//  done           out  1   one-cycle pulse; state_out* valid from this cycle until the next done
// BEHAVIOUR
//  Reset: FSM=IDLE, column counter=0, done=0, state_out0..3=32'h0, input and work buffers=0.
//  FSM states are IDLE and BUSY.
//  - IDLE: on an edge with start_in=1, latch state0..3 into the input buffer, clear counter, go to BUSY.
//  - BUSY: each edge transforms columns [cnt .. cnt+COLS_PER_CYCLE-1] from the input buffer into the work buffer.
//    The counter advances by COLS_PER_CYCLE. On the edge that writes column 3:
//    copy the full result to state_out0..3, set done=1 for that cycle, go to IDLE.
//  - Latency: start sampled at edge E0; done=1 and outputs updated after edge E0+L. done clears at E0+L+1.
//  Per-column math in GF(2^8), reduction polynomial x^8+x^4+x^3+x+1 (xtime: shift left, XOR 8'h1b if msb=1):
//    o0=0e*s0^0b*s1^0d*s2^09*s3   o1=09*s0^0e*s1^0b*s2^0d*s3
//    o2=0d*s0^09*s1^0e*s2^0b*s3   o3=0b*s0^0d*s1^09*s2^0e*s3
//    Build from xtime chains (x2, x4, x8); all intermediates are 8 bits; no multiplier inference.
//  Boundary conditions:
//  - start_in in BUSY is ignored. Input changes after the IDLE capture edge have no effect on the result.
//  - start_in held high: a new capture happens on the first edge in IDLE, i.e. back-to-back operations every L+1 cycles.
//    done pulses once per operation and never stays high for two consecutive cycles.
//  - state_out* change only on done edges; they hold their value while IDLE and while BUSY.
//  - reset mid-BUSY aborts the operation: no done pulse, outputs return to 0, and the next start begins cleanly.
//  - Counter never exceeds 3; illegal FSM encodings recover to IDLE.
// TESTING
//  T1 FIPS vector: state0=32'hbca14d8e (col db,13,53,45 mixed), start -> after L cycles state_out0=32'h455313db, done=1 for one cycle.
//  T2 multi-vector: state0..3 = 32'hbca14d8e, 32'h9d58dc9f, 32'h01010101, 32'hd6d7d5d5
//     -> outputs 32'h455313db, 32'h5c220af2, 32'h01010101, 32'hd5d4d4d4.
//  T3 round trip: drive aes_mixcolumns with 33221100/77665544/bbaa9988/ffeeddcc and feed its outputs here
//     -> outputs match the original inputs exactly; repeat for 200 random states.
//  T4 start_in held high for 3 operations with new inputs each time -> 3 single-cycle done pulses spaced L+1 cycles apart.
//     Inputs changed while BUSY are not reflected in that operation's result.
//  T5 reset asserted 2 cycles into BUSY -> done stays 0 and outputs read 0.
//     A fresh start after reset gives the T1 result with nominal latency.
//  T6 repeat T1-T5 for COLS_PER_CYCLE=1, 2, 4 -> done after 4, 2, 1 cycles respectively, with identical data.

Source files
------------

// File: rtl/aes_inv_mixcolumns.sv
// aes_inv_mixcolumns: iterative AES InvMixColumns over four 32-bit columns,
// COLS_PER_CYCLE columns per clock, with a one-cycle done pulse per operation.
module aes_inv_mixcolumns #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_in,
  input  logic [31:0] state0,
  input  logic [31:0] state1,
  input  logic [31:0] state2,
  input  logic [31:0] state3,
  output logic [31:0] state_out0,
  output logic [31:0] state_out1,
  output logic [31:0] state_out2,
  output logic [31:0] state_out3,
  output logic        done
);
  typedef enum logic {IDLE, BUSY} st_t;
  st_t              state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [3:0][31:0] in_q, in_d, work_q, work_d, out_q, out_d;
  logic             done_q, done_d;
  logic             last;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // 09/0b/0d/0e multiples are XOR combinations of the x2/x4/x8 chain
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [3:0][7:0] s, m9, mb, md, me;
    logic [7:0]      x2, x4, x8;
    logic [31:0]     o;
    for (int r = 0; r < 4; r++) begin
      s[r]  = c[8*r +: 8];
      x2    = xt(s[r]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[r] = x8 ^ s[r];
      mb[r] = x8 ^ x2 ^ s[r];
      md[r] = x8 ^ x4 ^ s[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    for (int r = 0; r < 4; r++)
      o[8*r +: 8] = me[r] ^ mb[2'(r + 1)] ^ md[2'(r + 2)] ^ m9[2'(r + 3)];
    return o;
  endfunction

  assign last = cnt_q == 2'(4 - COLS_PER_CYCLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    work_d  = work_q;
    out_d   = out_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start_in) begin
        in_d    = {state3, state2, state1, state0};
        cnt_d   = 2'd0;
        state_d = BUSY;
      end
    end else begin
      for (int j = 0; j < COLS_PER_CYCLE; j++)
        work_d[cnt_q + 2'(j)] = inv_col(in_q[cnt_q + 2'(j)]);
      cnt_d   = last ? 2'd0 : cnt_q + 2'(COLS_PER_CYCLE);
      out_d   = last ? work_d : out_q;
      done_d  = last;
      state_d = last ? IDLE : BUSY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      in_q    <= '0;
      work_q  <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      work_q  <= work_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign state_out0 = out_q[0];
  assign state_out1 = out_q[1];
  assign state_out2 = out_q[2];
  assign state_out3 = out_q[3];
  assign done       = done_q;
endmodule
